regfile_cz_param: RTL

//   Parametrised multicycle-core register file with architectural C/Z flags and
//   a dedicated PC slot. Sits between the ALU/memory writeback mux and the

---
 rtl/regfile_cz_param.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_cz_param.sv
// regfile_cz_param: parametrised register file with C/Z flags, PC slot and flag-gated conditional writes
// Ports: clk, rst_n (async active-low); pc_we/pc_in load rf[PC_REG]; we/cz_cond/wa/wd general write
// gated on pre-edge flags (cz_cond 00 always, 10 C, 01 Z, 11 C&Z); c_we/z_we/c_in/z_in flag update;
// ra1/ra2 -> rd1/rd2 and dbg_ra -> dbg_rd combinational reads; c_out/z_out flags;
// wr_done/wr_squash registered commit/suppress pulses.
// Build option REGFILE_BYPASS_EN adds same-cycle write-through on rd1/rd2 (never on dbg_rd).
module regfile_cz_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_we,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              we,
  input  logic [1:0]        cz_cond,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              c_we,
  input  logic              z_we,
  input  logic              c_in,
  input  logic              z_in,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic              c_out,
  output logic              z_out,
  output logic              wr_done,
  output logic              wr_squash
);
  localparam int NREGS = 2 ** ADDR_W;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic c_q, c_d, z_q, z_d, wr_done_q, wr_done_d, wr_squash_q, wr_squash_d;
  logic cond_ok, commit;
  always_comb begin
    cond_ok = (~cz_cond[1] | c_q) & (~cz_cond[0] | z_q);
    commit = we & cond_ok;
    for (int i = 0; i < NREGS; i++)
      rf_d[i] = (pc_we && i == PC_REG) ? pc_in : (commit && wa == ADDR_W'(i)) ? wd : rf_q[i];
    c_d = c_we ? c_in : c_q;
    z_d = z_we ? z_in : z_q;
    wr_done_d = commit;
    wr_squash_d = we & ~cond_ok;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rf_q <= '{default: '0};
      c_q <= 1'b0;
      z_q <= 1'b0;
      wr_done_q <= 1'b0;
      wr_squash_q <= 1'b0;
    end else begin
      rf_q <= rf_d;
      c_q <= c_d;
      z_q <= z_d;
      wr_done_q <= wr_done_d;
      wr_squash_q <= wr_squash_d;
    end
`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_REG);
  logic hit;
  // pc_in overrides a general write to the PC slot, so that write must not be forwarded
  assign hit = commit & ~(pc_we & (wa == PC_A));
  assign rd1 = (hit && ra1 == wa) ? wd : (pc_we && ra1 == PC_A) ? pc_in : rf_q[ra1];
  assign rd2 = (hit && ra2 == wa) ? wd : (pc_we && ra2 == PC_A) ? pc_in : rf_q[ra2];
`else
  assign rd1 = rf_q[ra1];
  assign rd2 = rf_q[ra2];
`endif
  assign dbg_rd = rf_q[dbg_ra];
  assign c_out = c_q;
  assign z_out = z_q;
  assign wr_done = wr_done_q;
  assign wr_squash = wr_squash_q;
endmodule
